vpad_event_counter: RTL and testbench

VPAD_EVENT_COUNTER -- requirements
Module: vpad_event_counter

---
 rtl/vpad_event_counter.sv | 164 ++++++++++++++++
 tb/tb_vpad_event_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vpad_event_counter.sv
// Four-board pad event counter: synchronizes and debounces 16 pad inputs,
// turns debounced rising edges into per-board count/mode actions and drives
// each board's LED byte from its count or from a rotating chase pattern.
module vpad_event_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CHASE_PERIOD    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pad_val,
  output logic [31:0] led_val,
  output logic [15:0] press
);

  localparam int unsigned NUM_PADS   = 16;
  localparam int unsigned NUM_BOARDS = 4;
  localparam int unsigned PADS_PER_B = 4;
  localparam int unsigned DCNT_W     = 8;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned PRESC_W    = 16;

  localparam logic [DCNT_W-1:0]  DEB_LIMIT  = DCNT_W'(DEBOUNCE_CYCLES);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CHASE_PERIOD - 1);
  localparam logic [BYTE_W-1:0]  CHASE_INIT = 8'h01;

  typedef enum logic {
    MODE_COUNT = 1'b0,
    MODE_CHASE = 1'b1
  } mode_e;

  // Input conditioning state
  logic [NUM_PADS-1:0] sync1_q, sync1_d;
  logic [NUM_PADS-1:0] sync2_q, sync2_d;
  logic [NUM_PADS-1:0] deb_q, deb_d;
  logic [NUM_PADS-1:0] deb_prev_q, deb_prev_d;
  logic [NUM_PADS-1:0][DCNT_W-1:0] dcnt_q, dcnt_d;

  // Per-board state
  logic [NUM_BOARDS-1:0][BYTE_W-1:0]  count_q, count_d;
  logic [NUM_BOARDS-1:0][BYTE_W-1:0]  chase_q, chase_d;
  logic [NUM_BOARDS-1:0][PRESC_W-1:0] presc_q, presc_d;
  mode_e                              mode_q [NUM_BOARDS];
  mode_e                              mode_d [NUM_BOARDS];

  // Registered outputs
  logic [NUM_PADS-1:0]             press_q, press_d;
  logic [NUM_BOARDS*BYTE_W-1:0]    led_q, led_d;

  // Debounced rising edges, regrouped per board: [b][0]=inc [1]=dec [2]=clr [3]=toggle
  logic [NUM_PADS-1:0]                   rise;
  logic [NUM_BOARDS-1:0][PADS_PER_B-1:0] act;

  assign rise    = deb_q & ~deb_prev_q;
  assign act     = rise;
  assign led_val = led_q;
  assign press   = press_q;

  // Two-flop synchronizer and per-bit debounce counters
  always_comb begin
    sync1_d    = pad_val;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    dcnt_d     = dcnt_q;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_LIMIT) begin
          deb_d[i]  = sync2_q[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
        end
      end else begin
        dcnt_d[i] = '0;
      end
    end
  end

  // Press pulses are the debounced rising edges, registered alongside the LED update
  always_comb begin
    press_d = rise;
  end

  // Per-board count actions, mode FSM next-state, chase prescaler and LED select
  always_comb begin
    count_d = count_q;
    chase_d = chase_q;
    presc_d = presc_q;
    led_d   = '0;
    for (int b = 0; b < NUM_BOARDS; b++) begin
      mode_d[b] = mode_q[b];

      // Clear wins; inc and dec together cancel
      if (act[b][2]) begin
        count_d[b] = '0;
      end else if (act[b][0] && !act[b][1]) begin
        count_d[b] = count_q[b] + BYTE_W'(1);
      end else if (act[b][1] && !act[b][0]) begin
        count_d[b] = count_q[b] - BYTE_W'(1);
      end

      case (mode_q[b])
        MODE_COUNT: begin
          presc_d[b] = '0;
          if (act[b][3]) begin
            mode_d[b]  = MODE_CHASE;
            chase_d[b] = CHASE_INIT;
          end
        end
        MODE_CHASE: begin
          if (act[b][3]) begin
            mode_d[b]  = MODE_COUNT;
            presc_d[b] = '0;
          end else if (presc_q[b] == PRESC_LAST) begin
            presc_d[b] = '0;
            chase_d[b] = {chase_q[b][BYTE_W-2:0], chase_q[b][BYTE_W-1]};
          end else begin
            presc_d[b] = presc_q[b] + PRESC_W'(1);
          end
        end
        default: begin
          mode_d[b]  = MODE_COUNT;
          presc_d[b] = '0;
        end
      endcase

      led_d[b*BYTE_W +: BYTE_W] = (mode_d[b] == MODE_CHASE) ? chase_d[b] : count_d[b];
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      dcnt_q     <= '0;
      count_q    <= '0;
      presc_q    <= '0;
      press_q    <= '0;
      led_q      <= '0;
      for (int b = 0; b < NUM_BOARDS; b++) begin
        chase_q[b] <= CHASE_INIT;
        mode_q[b]  <= MODE_COUNT;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      dcnt_q     <= dcnt_d;
      count_q    <= count_d;
      chase_q    <= chase_d;
      presc_q    <= presc_d;
      press_q    <= press_d;
      led_q      <= led_d;
      for (int b = 0; b < NUM_BOARDS; b++) begin
        mode_q[b] <= mode_d[b];
      end
    end
  end

endmodule

// File: tb/tb_vpad_event_counter.sv
// Scoreboard bench for vpad_event_counter: expected press/LED values are
// queued with their due cycle when pads are driven, and checked on the
// falling edge of that cycle; press must be idle on every other cycle.
module tb_vpad_event_counter;

  localparam int unsigned DB  = 4;
  localparam int unsigned CP  = 8;
  localparam int          LAT = DB + 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pad_val = 16'h0;
  logic [31:0] led_val;
  logic [15:0] press;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          at;
    logic [15:0] pr;
    logic [31:0] led;
    string       tag;
  } exp_t;

  exp_t sb[$];

  logic [7:0] mcount [4];
  logic       mmode  [4];
  int         mstart [4];

  vpad_event_counter #(.DEBOUNCE_CYCLES(DB), .CHASE_PERIOD(CP)) dut (
    .clock   (clock),
    .reset   (reset),
    .pad_val (pad_val),
    .led_val (led_val),
    .press   (press)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clock) begin
    bit hit;
    exp_t e;
    hit = 1'b0;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      check({e.tag, "_press"}, {16'h0, press}, {16'h0, e.pr});
      check({e.tag, "_led"}, led_val, e.led);
      hit = 1'b1;
    end
    if (!hit) check("idle_press", {16'h0, press}, 32'h0);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      mcount[b] = 8'h00;
      mmode[b]  = 1'b0;
      mstart[b] = 0;
    end
  endtask

  task automatic model_apply(input logic [15:0] mask, input int at);
    logic [3:0] a;
    for (int b = 0; b < 4; b++) begin
      a = mask[4*b +: 4];
      if (a[2])                mcount[b] = 8'h00;
      else if (a[0] && !a[1])  mcount[b] = mcount[b] + 8'h01;
      else if (a[1] && !a[0])  mcount[b] = mcount[b] - 8'h01;
      if (a[3]) begin
        if (!mmode[b]) mstart[b] = at;
        mmode[b] = !mmode[b];
      end
    end
  endtask

  function automatic logic [31:0] led_model(input int at);
    logic [31:0] r;
    logic [7:0]  one;
    int          steps;
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (mmode[b]) begin
        one   = 8'h01;
        steps = ((at - mstart[b]) / CP) % 8;
        r[8*b +: 8] = one << steps;
      end else begin
        r[8*b +: 8] = mcount[b];
      end
    end
    return r;
  endfunction

  task automatic expect_at(input int at, input logic [15:0] pr, input logic [31:0] led, input string tag);
    exp_t e;
    e.at = at; e.pr = pr; e.led = led; e.tag = tag;
    sb.push_back(e);
  endtask

  // Hold pads long enough to be accepted, then release and let the release settle
  task automatic tap(input logic [15:0] mask, input string tag);
    int at;
    at = cyc + LAT;
    pad_val = mask;
    model_apply(mask, at);
    expect_at(at, mask, led_model(at), tag);
    wait_cyc(10);
    pad_val = 16'h0;
    wait_cyc(10);
  endtask

  initial begin
    int at;
    model_reset();
    @(negedge clock);

    // Pads held high through reset
    pad_val = 16'hFFFF;
    wait_cyc(3);
    check("rst_led", led_val, 32'h0);
    check("rst_press", {16'h0, press}, 32'h0);
    reset = 1'b0;
    at = cyc + LAT;
    model_apply(16'hFFFF, at);
    expect_at(at, 16'hFFFF, led_model(at), "rst_hold");
    wait_cyc(12);
    pad_val = 16'h0;
    wait_cyc(12);

    // Reset while every board is chasing
    reset = 1'b1;
    wait_cyc(1);
    check("rst_mid_chase_led", led_val, 32'h0);
    wait_cyc(2);
    reset = 1'b0;
    model_reset();
    wait_cyc(12);
    check("post_rst_led", led_val, 32'h0);

    // Basic increment
    tap(16'h0001, "inc1");
    tap(16'h0001, "inc2");

    // Short glitch is rejected
    pad_val = 16'h0010;
    wait_cyc(3);
    pad_val = 16'h0;
    wait_cyc(14);
    check("glitch_led", led_val, 32'h00000002);

    // Decrement wrap then 256 increments back to 0xFF
    tap(16'h2000, "dec_wrap");
    for (int i = 0; i < 256; i++) tap(16'h1000, "inc_loop");
    check("inc_loop_led", {24'h0, led_val[31:24]}, 32'h000000FF);

    // Simultaneous press resolution
    repeat (3) tap(16'h0001, "to5");
    tap(16'h0005, "inc_clr");
    repeat (3) tap(16'h0001, "to3");
    tap(16'h0003, "inc_dec");

    // Chase mode from count 9
    repeat (6) tap(16'h0001, "to9");
    at = cyc + LAT;
    pad_val = 16'h0008;
    model_apply(16'h0008, at);
    expect_at(at, 16'h0008, led_model(at), "chase_in");
    for (int k = 1; k <= 9; k++)
      expect_at(at + k * CP, 16'h0, led_model(at + k * CP), "chase_step");
    wait_cyc(10);
    pad_val = 16'h0;
    while (cyc < at + 9 * CP + 3) wait_cyc(1);
    tap(16'h0001, "chase_inc");
    tap(16'h0008, "chase_out");
    check("chase_out_led", {24'h0, led_val[7:0]}, 32'h0000000A);

    // Reset during partial debounce progress
    pad_val = 16'h0001;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(2);
    pad_val = 16'h0;
    reset = 1'b0;
    model_reset();
    wait_cyc(14);
    check("rst_partial_led", led_val, 32'h0);

    check("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety bound
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL timeout: cycle=%0d limit reached", cyc);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
